vendo_input_cond: RTL and testbench
===================================

Name: vendo_input_cond

Overview:
- Front-end conditioner that sits directly upstream of the vending FSM (vendo).
- Takes four raw, asynchronous, bouncy inputs: coin slots p_1/p_5 and select buttons sel_A/sel_B.
- Produces clean one-cycle, mutually exclusive pulses that vendo's next-state logic consumes directly.
- Also guarantees vendo never sees coin==2'b11 or sel==2'b11.

Parameters:
- DB_CYCLES, 4: consecutive synchronized samples that must differ from the debounced level before it flips; legal range 2..2**CNT_W.
- CNT_W, 5: debounce counter width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- p_1_raw  in  1  raw 1-peso coin sensor, asynchronous
- p_5_raw  in  1  raw 5-peso coin sensor, asynchronous
- sel_A_raw  in  1  raw item-A button, asynchronous
- sel_B_raw  in  1  raw item-B button, asynchronous
- p_1  out  1  one-cycle pulse to vendo
- p_5  out  1  one-cycle pulse to vendo
- sel_A  out  1  one-cycle pulse to vendo
- sel_B  out  1  one-cycle pulse to vendo
- overrun  out  1  one-cycle pulse: a new press was merged into an already-pending one
- coin_total  out  8  saturating peso tally (only with VENDO_COIN_TALLY_EN)

Behaviour:
- Reset: while rst is high at a posedge, clear every sync FF, debounced level, counter, pending bit, previous-level register and output to 0.
- A button held through reset reads as a rising edge after reset and yields one pulse after full debounce latency.
- Per channel, synchronizer: 2-FF chain s1 to s2.
- Per channel, debounce:
  - If s2 == db, cnt <= 0.
  - Else if cnt == DB_CYCLES-1, db <= s2 and cnt <= 0.
  - Else cnt <= cnt+1.
  - Any mismatch-free sample restarts the count, which absorbs bounce.
- Rise detect: rise = db & ~db_q, where db_q is the registered db. Falling edges are debounced too but produce no pulse.
- Pending: rise sets pend[ch]. If pend[ch] is already set and not granted this cycle, the new press is merged and overrun pulses once.
- Arbiter, fixed priority p_1 > p_5 > sel_A > sel_B:
  - Each cycle the highest-priority pending bit is granted.
  - The granted bit is cleared, and the matching output register is set for exactly one cycle.
  - All other outputs are 0 that cycle; at most one output is ever high.
- Simultaneous grant and rise on the same channel: pend stays set, giving a second pulse next cycle; no overrun.
- Latency with raw held high from posedge 0: db high after posedge DB_CYCLES+1; pend after DB_CYCLES+2; output high during the cycle after posedge DB_CYCLES+3. For DB_CYCLES=4 that is 7 cycles.
- Queued events drain one per cycle in priority order.
- No ready/backpressure from vendo: vendo consumes every pulse it is in a state to accept and ignores the rest. That policy is vendo's, not this block's.

Optional Feature:
- Macro: VENDO_COIN_TALLY_EN.
- Defined:
  - coin_total adds 1 on each p_1 pulse and 5 on each p_5 pulse, saturating at 255.
  - Cleared by rst.
  - Updated at the same posedge as the pulse is registered, so it is visible together with the pulse.
- Undefined:
  - Port and logic are absent.
  - All other behaviour is identical.

Decomposition:
- Package vendo_pkg holds:
  - channel indices CH_P1=0, CH_P5=1, CH_SELA=2, CH_SELB=3, NUM_CH=4;
  - coin values VAL_P1=1, VAL_P5=5;
  - TALLY_W=8.
- Sub-module vendo_debounce holds the synchronizer, counter, db and db_q, and outputs rise. It is instantiated NUM_CH times.
- Pending bits, arbiter, overrun and tally stay in the top.

Test Plan (DB_CYCLES=4):
1. p_1_raw rises before posedge 0 and is held 10 cycles -> a single p_1 pulse after posedge 7; p_5, sel_A and sel_B stay 0; overrun stays 0.
2. p_5_raw toggles every cycle for 6 cycles, then is held high -> exactly one p_5 pulse, 7 cycles after the first stable-high posedge; no pulse during bounce.
3. p_1_raw and p_5_raw rise together -> p_1 pulse in cycle 7, p_5 pulse in cycle 8; never both high.
4. sel_A_raw high from cycle 0; rst high in cycles 4-5 -> no pulse before reset; sel_A pulses 7 cycles after the first posedge with rst low.
5. sel_B held 50 cycles, low 10, high again -> exactly two sel_B pulses, none on release.
6. With VENDO_COIN_TALLY_EN: p_1, p_5, p_5 -> coin_total=11; then 50 more p_5 -> coin_total=255 and stays there; rst -> 0.

Source files
------------

// File: rtl/vendo_pkg.sv
// vendo_pkg: shared constants and helpers for the vendo front end.
// Channel indices set the bit position of each input in every per-channel
// vector and also set arbitration priority: the lower index wins.
package vendo_pkg;

   localparam int CH_P1   = 0;
   localparam int CH_P5   = 1;
   localparam int CH_SELA = 2;
   localparam int CH_SELB = 3;
   localparam int NUM_CH  = 4;

   localparam int VAL_P1  = 1;
   localparam int VAL_P5  = 5;

   localparam int TALLY_W = 8;

   typedef logic [NUM_CH-1:0] ch_vec_t;

   // One-hot grant of the lowest-index (highest-priority) request bit.
   function automatic ch_vec_t prio_grant(input ch_vec_t req);
      ch_vec_t g;
      g = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (req[i]) begin
            g    = '0;
            g[i] = 1'b1;
         end
      end
      return g;
   endfunction

   // Unsigned add that sticks at all-ones instead of wrapping.
   function automatic logic [TALLY_W-1:0] sat_add(input logic [TALLY_W-1:0] a,
                                                 input logic [TALLY_W-1:0] b);
      logic [TALLY_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[TALLY_W] ? '1 : s[TALLY_W-1:0];
   endfunction

endpackage

// File: rtl/vendo_debounce.sv
// vendo_debounce: one input channel of the conditioner.
// 2-FF synchronizer, counter-based debouncer and rising-edge detector.
// The debounced level only flips after DB_CYCLES consecutive synchronized
// samples disagree with it; any agreeing sample restarts the count, so
// contact bounce never reaches the level.
module vendo_debounce #(
   parameter int DB_CYCLES = 4,
   parameter int CNT_W     = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic rise_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             s1_q, s2_q;
   logic             db_q, db_d;
   logic             db_prev_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Debounce next state: count disagreeing samples, flip on the last one.
   always_comb begin
      db_d  = db_q;
      cnt_d = cnt_q;
      if (s2_q == db_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         db_d  = s2_q;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // Synchronizer chain, debounce state and previous-level register.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         db_q      <= 1'b0;
         db_prev_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         s1_q      <= raw_i;
         s2_q      <= s1_q;
         db_q      <= db_d;
         db_prev_q <= db_q;
         cnt_q     <= cnt_d;
      end
   end

   // Only the low-to-high transition of the clean level is an event.
   assign rise_o = db_q & ~db_prev_q;

endmodule

// File: rtl/vendo_input_cond.sv
// vendo_input_cond: conditions the raw coin slots and select buttons into
// clean, mutually exclusive one-cycle pulses for the vendo FSM.
// Optional build macro VENDO_COIN_TALLY_EN adds the coin_total output, a
// saturating peso tally updated together with each coin pulse.
//
// Interface note: there is no valid/ready handshake. Each output is a bare
// one-cycle strobe; the consumer takes it or ignores it, and nothing here
// waits on the consumer.
module vendo_input_cond
   import vendo_pkg::*;
#(
   parameter int DB_CYCLES = 4,
   parameter int CNT_W     = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic p_1_raw,
   input  logic p_5_raw,
   input  logic sel_A_raw,
   input  logic sel_B_raw,
   output logic p_1,
   output logic p_5,
   output logic sel_A,
   output logic sel_B,
   output logic overrun
`ifdef VENDO_COIN_TALLY_EN
   ,
   output logic [TALLY_W-1:0] coin_total
`endif
);

   ch_vec_t raw_vec;
   ch_vec_t rise;
   ch_vec_t grant;
   ch_vec_t pend_q, pend_d;
   ch_vec_t pulse_q, pulse_d;
   logic    overrun_q, overrun_d;

   assign raw_vec[CH_P1]   = p_1_raw;
   assign raw_vec[CH_P5]   = p_5_raw;
   assign raw_vec[CH_SELA] = sel_A_raw;
   assign raw_vec[CH_SELB] = sel_B_raw;

   // One synchronizer/debouncer/edge detector per input channel.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      vendo_debounce #(
         .DB_CYCLES(DB_CYCLES),
         .CNT_W    (CNT_W)
      ) u_db (
         .clk   (clk),
         .rst   (rst),
         .raw_i (raw_vec[g]),
         .rise_o(rise[g])
      );
   end

   // Pending set/clear, fixed-priority grant and overrun detection.
   // A rise on the channel being granted this cycle re-arms its pending
   // bit, so that press becomes a second pulse rather than an overrun.
   always_comb begin
      grant     = prio_grant(pend_q);
      pend_d    = (pend_q & ~grant) | rise;
      pulse_d   = grant;
      overrun_d = |(rise & pend_q & ~grant);
   end

   // Pending bits and registered output strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q    <= '0;
         pulse_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         pend_q    <= pend_d;
         pulse_q   <= pulse_d;
         overrun_q <= overrun_d;
      end
   end

   assign p_1     = pulse_q[CH_P1];
   assign p_5     = pulse_q[CH_P5];
   assign sel_A   = pulse_q[CH_SELA];
   assign sel_B   = pulse_q[CH_SELB];
   assign overrun = overrun_q;

`ifdef VENDO_COIN_TALLY_EN
   logic [TALLY_W-1:0] tally_q, tally_d;
   logic [TALLY_W-1:0] tally_inc;

   // Tally next state: keyed off the same grant that loads the pulse
   // register, so the new total appears in the same cycle as the pulse.
   always_comb begin
      tally_inc = '0;
      if (grant[CH_P1]) begin
         tally_inc = TALLY_W'(VAL_P1);
      end else if (grant[CH_P5]) begin
         tally_inc = TALLY_W'(VAL_P5);
      end
      tally_d = sat_add(tally_q, tally_inc);
   end

   // Tally register.
   always_ff @(posedge clk) begin
      if (rst) begin
         tally_q <= '0;
      end else begin
         tally_q <= tally_d;
      end
   end

   assign coin_total = tally_q;
`endif

endmodule

// File: tb/tb_vendo_input_cond.sv
// tb_vendo_input_cond: directed bench for vendo_input_cond with DB_CYCLES=4.
// Cycle k is the interval after posedge k; the raw value passed for step k
// is the value present at posedge k, outputs are read at the following
// negedge. Output vectors are {overrun, sel_B, sel_A, p_5, p_1}.
module tb_vendo_input_cond;

   localparam int LAT = 7;   // raw-high posedge to pulse cycle at DB_CYCLES=4
   localparam int WIN = 24;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1;
   logic p_1_raw = 1'b0, p_5_raw = 1'b0, sel_A_raw = 1'b0, sel_B_raw = 1'b0;
   logic p_1, p_5, sel_A, sel_B, overrun;
`ifdef VENDO_COIN_TALLY_EN
   logic [7:0] coin_total;
   int         exp_total;
`endif

   vendo_input_cond #(
      .DB_CYCLES(4),
      .CNT_W    (5)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .p_1_raw  (p_1_raw),
      .p_5_raw  (p_5_raw),
      .sel_A_raw(sel_A_raw),
      .sel_B_raw(sel_B_raw),
      .p_1      (p_1),
      .p_5      (p_5),
      .sel_A    (sel_A),
      .sel_B    (sel_B),
      .overrun  (overrun)
`ifdef VENDO_COIN_TALLY_EN
      ,
      .coin_total(coin_total)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Vector record: raw mask held for 'hold' posedges starting at posedge 0,
   // expected pulse cycle per channel (-1 = no pulse in the window).
   typedef struct {
      logic [3:0] mask;
      int         hold;
      int         e_p1;
      int         e_p5;
      int         e_sa;
      int         e_sb;
   } vec_t;

   vec_t vecs[11];

   task automatic cyc(input logic [3:0] raw, input logic r, output logic [4:0] o);
      rst       = r;
      p_1_raw   = raw[0];
      p_5_raw   = raw[1];
      sel_A_raw = raw[2];
      sel_B_raw = raw[3];
      @(posedge clk);
      @(negedge clk);
      o = {overrun, sel_B, sel_A, p_5, p_1};
   endtask

   task automatic check5(input string nm, input int k, input logic [4:0] got,
                         input logic [4:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: outputs %b, expected %b", nm, k, got, exp);
      end
   endtask

   task automatic step(input string nm, input int k, input logic [3:0] raw,
                       input logic r, input logic [4:0] exp);
      logic [4:0] o;
      cyc(raw, r, o);
      check5(nm, k, o, exp);
   endtask

   task automatic do_reset();
      step("reset", 0, 4'b0000, 1'b1, 5'b00000);
      step("reset", 1, 4'b0000, 1'b1, 5'b00000);
   endtask

   function automatic logic [4:0] exp_of(input vec_t v, input int k);
      logic [4:0] e;
      e    = 5'b00000;
      e[0] = (k == v.e_p1);
      e[1] = (k == v.e_p5);
      e[2] = (k == v.e_sa);
      e[3] = (k == v.e_sb);
      return e;
   endfunction

`ifdef VENDO_COIN_TALLY_EN
   task automatic check8(input string nm, input logic [7:0] got, input int exp);
      n_checks++;
      if (got !== 8'(exp)) begin
         n_fail++;
         $display("FAIL %s: coin_total %0d, expected %0d", nm, got, exp);
      end
   endtask

   // One press of channel ch (0 = p_1, 1 = p_5): 10 cycles high, 10 low.
   task automatic press_coin(input int ch);
      logic [4:0] o;
      logic [3:0] raw;
      int         seen;
      int         val;
      seen = 0;
      val  = (ch == 0) ? 1 : 5;
      for (int k = 0; k < 20; k++) begin
         raw = (k < 10) ? (4'b0001 << ch) : 4'b0000;
         cyc(raw, 1'b0, o);
         if (o[ch]) begin
            seen++;
            exp_total = (exp_total + val > 255) ? 255 : exp_total + val;
            check8("tally_with_pulse", coin_total, exp_total);
         end
      end
      n_checks++;
      if (seen != 1) begin
         n_fail++;
         $display("FAIL coin_press_count ch %0d: pulses %0d, expected 1", ch, seen);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] raw;
      logic [4:0] e;

      vecs[0]  = '{4'b0001, 10, LAT,   -1,    -1,    -1};
      vecs[1]  = '{4'b0010, 10, -1,    LAT,   -1,    -1};
      vecs[2]  = '{4'b0100, 10, -1,    -1,    LAT,   -1};
      vecs[3]  = '{4'b1000, 10, -1,    -1,    -1,    LAT};
      vecs[4]  = '{4'b0011, 10, LAT,   LAT+1, -1,    -1};
      vecs[5]  = '{4'b1111, 10, LAT,   LAT+1, LAT+2, LAT+3};
      vecs[6]  = '{4'b1100, 10, -1,    -1,    LAT,   LAT+1};
      vecs[7]  = '{4'b0001,  3, -1,    -1,    -1,    -1};
      vecs[8]  = '{4'b0001,  4, LAT,   -1,    -1,    -1};
      vecs[9]  = '{4'b1010,  4, -1,    LAT,   -1,    LAT+1};
      vecs[10] = '{4'b0110,  3, -1,    -1,    -1,    -1};

      // Table-driven single-press and simultaneous-press vectors.
      for (int v = 0; v < 11; v++) begin
         do_reset();
         for (int k = 0; k < WIN; k++) begin
            raw = (k < vecs[v].hold) ? vecs[v].mask : 4'b0000;
            step($sformatf("vec%0d", v), k, raw, 1'b0, exp_of(vecs[v], k));
         end
      end

      // Bounce: p_5 toggles for 6 posedges, then stable high from posedge 6.
      do_reset();
      for (int k = 0; k < WIN; k++) begin
         raw = (k < 6) ? ((k % 2 == 0) ? 4'b0010 : 4'b0000) : 4'b0010;
         e   = (k == 6 + LAT) ? 5'b00010 : 5'b00000;
         step("bounce_p5", k, raw, 1'b0, e);
      end

      // sel_A held from posedge 0, reset asserted at posedges 4 and 5.
      do_reset();
      for (int k = 0; k < WIN; k++) begin
         e = (k == 6 + LAT) ? 5'b00100 : 5'b00000;
         step("reset_mid_hold", k, 4'b0100, (k == 4 || k == 5), e);
      end

      // sel_B: 50 high, 10 low, 20 high -> two pulses, none on release.
      do_reset();
      for (int k = 0; k < 80; k++) begin
         raw = (k < 50 || k >= 60) ? 4'b1000 : 4'b0000;
         e   = (k == LAT || k == 60 + LAT) ? 5'b01000 : 5'b00000;
         step("selb_twice", k, raw, 1'b0, e);
      end

`ifdef VENDO_COIN_TALLY_EN
      do_reset();
      exp_total = 0;
      check8("tally_after_reset", coin_total, 0);
      press_coin(0);
      press_coin(1);
      press_coin(1);
      check8("tally_11", coin_total, 11);
      for (int i = 0; i < 50; i++) press_coin(1);
      check8("tally_saturated", coin_total, 255);
      do_reset();
      check8("tally_cleared", coin_total, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
